uart_rx_buffered: RTL and testbench
===================================

# uart_rx_buffered

Buffered UART receiver for the Baby Risco 5 SOC. It samples the asynchronous `rx` pin, deframes 8N1 characters at `BIT_RATE`, and queues the received bytes in a FIFO. The SOC's memory-mapped UART peripheral reads bytes from the FIFO through a one-cycle read strobe. It is the receive-side counterpart of the SOC's transmit path on the same serial link.

## Interface
- `CLOCK_FREQ`, 25000000, system clock frequency in Hz.
- `BIT_RATE`, 115200, serial bit rate in baud.
- `BUFFER_SIZE`, 16, FIFO depth in bytes; must be a power of two, at least 2.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idle level is high.
- `rd_en`  in  1  read strobe; pops one byte when `empty`=0.
- `rd_data`  out  8  byte popped by the most recent accepted read.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is valid in this cycle.
- `empty`  out  1  FIFO holds 0 bytes.
- `full`  out  1  FIFO holds `BUFFER_SIZE` bytes.
- `count`  out  $clog2(BUFFER_SIZE)+1  number of bytes in the FIFO.
- `overrun`  out  1  sticky; a received byte was dropped because the FIFO was full.
- `frame_error`  out  1  sticky; a stop bit was sampled low.
- `clear_errors`  in  1  one-cycle pulse; clears `overrun`, `frame_error`, and `parity_error` when present.

## Operation
- `rx` passes through a 2-flop synchronizer, whose flops reset to 1. All decisions use the synchronized value.
- Bit period is `BIT_TICKS = CLOCK_FREQ/BIT_RATE`, using integer division; at the default parameters this is 217. The bit counter width is $clog2(BIT_TICKS).
- Receiver FSM states: IDLE, START, DATA, STOP, plus PARITY when parity is enabled.
  - IDLE: a synchronized low moves the FSM to START and clears the tick counter.
  - START: at tick `BIT_TICKS/2` (108), `rx` is re-sampled.
    - If `rx` is high, the low was a glitch; return to IDLE with no flags set.
    - If `rx` is low, go to DATA and restart the tick counter.
  - DATA: sample at each tick `BIT_TICKS-1`, which is mid-bit. Shift the bit in LSB first. After 8 bits, go to STOP.
  - STOP: sample once.
    - High: the byte is pushed into the FIFO.
    - Low: the byte is discarded and `frame_error` is set.
    - In both cases the FSM returns to IDLE on the sample cycle, so back-to-back characters are accepted.
- FIFO:
  - Read and write pointers are $clog2(BUFFER_SIZE) bits and wrap naturally.
  - `count` is tracked as its own counter.
  - Push when full: the byte is dropped, `overrun` is set, and FIFO contents are unchanged.
  - Read when empty: ignored; `rd_valid` stays 0 and `rd_data` holds its value.
  - Push and accepted pop in the same cycle: both happen and `count` is unchanged. This also applies when full, because the pop is evaluated first, so no overrun occurs.
- Sticky flags:
  - A flag is set when its error condition occurs.
  - `clear_errors` clears the flags.
  - If an error and `clear_errors` occur in the same cycle, the flag ends set; the set wins.
- Reset:
  - Returns the FSM to IDLE and empties the FIFO, discarding any partial character.
  - A character already in progress on the line when reset deasserts is treated as line noise. If its start bit has passed, the FSM waits in IDLE for the next falling edge.

## Timing
- Reset values:
  - `rd_data` = 8'h00, `rd_valid` = 0, `empty` = 1, `full` = 0, `count` = 0.
  - `overrun` = 0, `frame_error` = 0, `parity_error` = 0.
- Latency:
  - A byte enters the FIFO, with `empty` deasserting, one cycle after the stop-bit sample cycle.
  - This is about 9.5 bit periods plus 3 cycles after the falling edge of the start bit; the 3 cycles are 2 for the synchronizer and 1 for the register.
- Read: `rd_en` sampled high in cycle N with `empty`=0 gives `rd_data`/`rd_valid` in cycle N+1. `count`, `empty`, and `full` also update in cycle N+1.
- Back-to-back `rd_en` sustains one byte per cycle.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame is 8E1. The PARITY state follows DATA and samples the even-parity bit one bit period later.
  - On mismatch the byte is dropped, the sticky output `parity_error` is set, and the FSM still checks the stop bit. A frame error may also be set on the same character.
- `UART_RX_PARITY_EN` undefined:
  - The frame is 8N1 with no PARITY state.
  - The `parity_error` port is absent.

## Test plan
- Reset, then send 0x55 at 115200 baud with a 25 MHz clock (217-cycle bits) -> `count`=1 and `empty`=0. A subsequent `rd_en` gives `rd_data`=0x55 with `rd_valid` one cycle later, then `empty`=1.
- Send 17 bytes 0x00–0x10 with no reads -> `full`=1, `count`=16, `overrun`=1. Reads return 0x00–0x0F in order. After `clear_errors`, `overrun`=0.
- Send 0xA3 with its stop bit driven low -> FIFO stays empty and `frame_error`=1. A following valid 0x3A is received correctly.
- Drive a 50-cycle low glitch on idle `rx` -> no byte, no flags, FSM back in IDLE.
- With the FIFO full, complete a byte in the same cycle as `rd_en` -> `count` stays 16, `overrun`=0, and the new byte is read last.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 (wrong, since the correct even parity is 1) -> byte dropped and `parity_error`=1. Send 0x07 with parity bit 1 -> byte accepted.

Source files
------------

// File: rtl/uart_rx_buffered_if.sv
// uart_rx_buffered_if: read/status bus between the UART receive FIFO and the SOC peripheral
interface uart_rx_buffered_if #(parameter int BUFFER_SIZE = 16);
  logic rd_en;
  logic [7:0] rd_data;
  logic rd_valid;
  logic empty;
  logic full;
  logic [$clog2(BUFFER_SIZE):0] count;
  logic overrun;
  logic frame_error;
  logic clear_errors;
`ifdef UART_RX_PARITY_EN
  logic parity_error;
  modport master(output rd_en, clear_errors,
                 input rd_data, rd_valid, empty, full, count, overrun, frame_error, parity_error);
  modport slave(input rd_en, clear_errors,
                output rd_data, rd_valid, empty, full, count, overrun, frame_error, parity_error);
`else
  modport master(output rd_en, clear_errors,
                 input rd_data, rd_valid, empty, full, count, overrun, frame_error);
  modport slave(input rd_en, clear_errors,
                output rd_data, rd_valid, empty, full, count, overrun, frame_error);
`endif
endinterface

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver feeding a byte FIFO; define UART_RX_PARITY_EN for 8E1 with parity_error
module uart_rx_buffered #(
  parameter int CLOCK_FREQ = 25000000,
  parameter int BIT_RATE = 115200,
  parameter int BUFFER_SIZE = 16
) (
  input logic clk,
  input logic reset,
  input logic rx,
  uart_rx_buffered_if.slave bus
);
  localparam int BIT_TICKS = CLOCK_FREQ / BIT_RATE;
  localparam int TW = $clog2(BIT_TICKS);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] MID = TW'(BIT_TICKS / 2);
  localparam logic [TW-1:0] LAST = TW'(BIT_TICKS - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state;
  logic rx_m, rx_s;
  logic [TW-1:0] tick;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic stop_smp, push, push_ok, pop, ferr;
  logic [7:0] mem [BUFFER_SIZE];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
`ifdef UART_RX_PARITY_EN
  logic par_bad, perr;
  assign perr = state == PARITY && tick == LAST && rx_s != ^shift;
  assign push = stop_smp && rx_s && !par_bad;
`else
  assign push = stop_smp && rx_s;
`endif
  assign stop_smp = state == STOP && tick == LAST;
  assign ferr = stop_smp && !rx_s;
  // pop is evaluated first so a push into a full FIFO still lands when a read frees a slot
  assign pop = bus.rd_en && count != '0;
  assign push_ok = push && (count != CW'(BUFFER_SIZE) || pop);
  assign bus.count = count;
  assign bus.empty = count == '0;
  assign bus.full = count == CW'(BUFFER_SIZE);
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      tick <= '0;
      bit_idx <= '0;
      shift <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      tick <= tick + 1'b1;
      case (state)
        IDLE: begin
          tick <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end
        START: if (tick == MID) begin
          tick <= '0;
          state <= rx_s ? IDLE : DATA;
        end
        DATA: if (tick == LAST) begin
          tick <= '0;
          shift <= {rx_s, shift[7:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= AFTER_DATA;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick == LAST) begin
          tick <= '0;
          par_bad <= rx_s != ^shift;
          state <= STOP;
        end
`endif
        STOP: if (tick == LAST) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) if (push_ok) mem[wr_ptr] <= shift;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      bus.rd_data <= 8'h00;
      bus.rd_valid <= 1'b0;
      bus.overrun <= 1'b0;
      bus.frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.parity_error <= 1'b0;
`endif
    end else begin
      bus.rd_valid <= pop;
      if (pop) begin
        bus.rd_data <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
      bus.overrun <= (bus.overrun && !bus.clear_errors) || (push && !push_ok);
      bus.frame_error <= (bus.frame_error && !bus.clear_errors) || ferr;
`ifdef UART_RX_PARITY_EN
      bus.parity_error <= (bus.parity_error && !bus.clear_errors) || perr;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: randomized self-checking bench against a queue-based receiver model
module tb_uart_rx_buffered;
  localparam int BIT = 217;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // cycle whose rd_en coincides with the FIFO write: 2 sync + 1 idle edge, mid-start, then NB-1 full bits
  localparam int POP_AT = 3 + BIT / 2 + (NB - 1) * BIT;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  logic [7:0] q[$];
  bit m_over, m_ferr, m_perr;
  logic [7:0] d, e, b;
  logic v;
  uart_rx_buffered_if #(.BUFFER_SIZE(16)) bus();
  uart_rx_buffered #(.CLOCK_FREQ(25000000), .BIT_RATE(115200), .BUFFER_SIZE(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .bus(bus)
  );
  always #20 clk = ~clk;
  task automatic send(input logic [7:0] by, input bit stop_ok, input bit par_ok, input int pop_at);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = by;
    f[9] = ^by ^ !par_ok;
    f[NB-1] = stop_ok;
    for (int c = 0; c < NB * BIT; c++) begin
      rx = f[c / BIT];
      bus.rd_en = (c == pop_at);
      @(posedge clk);
    end
    rx = 1'b1;
    bus.rd_en = 1'b0;
    repeat (BIT) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic model_frame(input logic [7:0] by, input bit stop_ok, input bit par_ok);
    if (!par_ok) m_perr = 1;
    if (!stop_ok) m_ferr = 1;
    if (stop_ok && par_ok) begin
      if (q.size() == 16) m_over = 1;
      else q.push_back(by);
    end
  endtask
  task automatic read_strobe(output logic [7:0] rd, output logic rv);
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    rd = bus.rd_data;
    rv = bus.rd_valid;
  endtask
  task automatic clear_pulse;
    @(negedge clk);
    bus.clear_errors = 1'b1;
    @(negedge clk);
    bus.clear_errors = 1'b0;
    m_over = 0;
    m_ferr = 0;
    m_perr = 0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    rx = 1'b1;
    bus.rd_en = 1'b0;
    bus.clear_errors = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_over = 0;
    m_ferr = 0;
    m_perr = 0;
    @(negedge clk);
    n_total++; if (bus.rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h expected 00", bus.rd_data); else n_pass++;
    n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); else n_pass++;
    n_total++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", bus.empty); else n_pass++;
    n_total++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b expected 0", bus.full); else n_pass++;
    n_total++; if (bus.count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", bus.count); else n_pass++;
    n_total++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", bus.overrun); else n_pass++;
    n_total++; if (bus.frame_error !== 1'b0) $display("FAIL reset_frame_error: got %b expected 0", bus.frame_error); else n_pass++;
`ifdef UART_RX_PARITY_EN
    n_total++; if (bus.parity_error !== 1'b0) $display("FAIL reset_parity_error: got %b expected 0", bus.parity_error); else n_pass++;
`endif
  endtask
  task automatic test_single;
    send(8'h55, 1, 1, -1);
    model_frame(8'h55, 1, 1);
    n_total++; if (bus.count !== 5'(q.size())) $display("FAIL single_count: got %0d expected %0d", bus.count, q.size()); else n_pass++;
    n_total++; if (bus.empty !== 1'b0) $display("FAIL single_empty: got %b expected 0", bus.empty); else n_pass++;
    read_strobe(d, v);
    e = q.pop_front();
    n_total++; if (v !== 1'b1) $display("FAIL single_rd_valid: got %b expected 1", v); else n_pass++;
    n_total++; if (d !== e) $display("FAIL single_rd_data: got %h expected %h", d, e); else n_pass++;
    n_total++; if (bus.empty !== 1'b1) $display("FAIL single_empty_after: got %b expected 1", bus.empty); else n_pass++;
    read_strobe(d, v);
    n_total++; if (v !== 1'b0) $display("FAIL empty_read_valid: got %b expected 0", v); else n_pass++;
    n_total++; if (d !== e) $display("FAIL empty_read_hold: got %h expected %h", d, e); else n_pass++;
  endtask
  task automatic test_random;
    repeat (4) begin
      b = 8'($urandom);
      send(b, 1, 1, -1);
      model_frame(b, 1, 1);
      n_total++; if (bus.count !== 5'(q.size())) $display("FAIL random_count: got %0d expected %0d", bus.count, q.size()); else n_pass++;
    end
    while (q.size() > 0) begin
      read_strobe(d, v);
      e = q.pop_front();
      n_total++; if (v !== 1'b1 || d !== e) $display("FAIL random_read: got %b/%h expected 1/%h", v, d, e); else n_pass++;
    end
    n_total++; if (bus.overrun !== m_over || bus.frame_error !== m_ferr) $display("FAIL random_flags: got %b%b expected %b%b", bus.overrun, bus.frame_error, m_over, m_ferr); else n_pass++;
  endtask
  task automatic test_overrun_full_pop;
    for (int i = 0; i <= 16; i++) begin
      send(8'(i), 1, 1, -1);
      model_frame(8'(i), 1, 1);
    end
    n_total++; if (bus.full !== 1'b1) $display("FAIL ovr_full: got %b expected 1", bus.full); else n_pass++;
    n_total++; if (bus.count !== 5'(q.size())) $display("FAIL ovr_count: got %0d expected %0d", bus.count, q.size()); else n_pass++;
    n_total++; if (bus.overrun !== m_over) $display("FAIL ovr_overrun: got %b expected %b", bus.overrun, m_over); else n_pass++;
    clear_pulse();
    n_total++; if (bus.overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", bus.overrun); else n_pass++;
    b = 8'hC5;
    e = q.pop_front();
    q.push_back(b);
    send(b, 1, 1, POP_AT);
    n_total++; if (bus.rd_data !== e) $display("FAIL fullpop_rd_data: got %h expected %h", bus.rd_data, e); else n_pass++;
    n_total++; if (bus.count !== 5'(q.size())) $display("FAIL fullpop_count: got %0d expected %0d", bus.count, q.size()); else n_pass++;
    n_total++; if (bus.overrun !== 1'b0) $display("FAIL fullpop_overrun: got %b expected 0", bus.overrun); else n_pass++;
    bus.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) bus.rd_en = 1'b0;
      e = q.pop_front();
      n_total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) $display("FAIL b2b_read%0d: got %b/%h expected 1/%h", i, bus.rd_valid, bus.rd_data, e); else n_pass++;
    end
    @(negedge clk);
    n_total++; if (bus.empty !== 1'b1) $display("FAIL b2b_empty: got %b expected 1", bus.empty); else n_pass++;
  endtask
  task automatic test_frame_error;
    send(8'hA3, 0, 1, -1);
    model_frame(8'hA3, 0, 1);
    n_total++; if (bus.empty !== 1'b1) $display("FAIL ferr_empty: got %b expected 1", bus.empty); else n_pass++;
    n_total++; if (bus.frame_error !== m_ferr) $display("FAIL ferr_flag: got %b expected %b", bus.frame_error, m_ferr); else n_pass++;
    send(8'h3A, 1, 1, -1);
    model_frame(8'h3A, 1, 1);
    read_strobe(d, v);
    e = q.pop_front();
    n_total++; if (v !== 1'b1 || d !== e) $display("FAIL ferr_next_byte: got %b/%h expected 1/%h", v, d, e); else n_pass++;
    clear_pulse();
    n_total++; if (bus.frame_error !== 1'b0) $display("FAIL ferr_clear: got %b expected 0", bus.frame_error); else n_pass++;
  endtask
  task automatic test_glitch;
    @(negedge clk);
    rx = 1'b0;
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    n_total++; if (bus.count !== 5'd0) $display("FAIL glitch_count: got %0d expected 0", bus.count); else n_pass++;
    n_total++; if (bus.frame_error !== 1'b0 || bus.overrun !== 1'b0) $display("FAIL glitch_flags: got %b%b expected 00", bus.frame_error, bus.overrun); else n_pass++;
    b = 8'($urandom);
    send(b, 1, 1, -1);
    model_frame(b, 1, 1);
    read_strobe(d, v);
    e = q.pop_front();
    n_total++; if (v !== 1'b1 || d !== e) $display("FAIL glitch_next_byte: got %b/%h expected 1/%h", v, d, e); else n_pass++;
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    send(8'h07, 1, 0, -1);
    model_frame(8'h07, 1, 0);
    n_total++; if (bus.empty !== 1'b1) $display("FAIL par_empty: got %b expected 1", bus.empty); else n_pass++;
    n_total++; if (bus.parity_error !== m_perr) $display("FAIL par_flag: got %b expected %b", bus.parity_error, m_perr); else n_pass++;
    n_total++; if (bus.frame_error !== m_ferr) $display("FAIL par_ferr: got %b expected %b", bus.frame_error, m_ferr); else n_pass++;
    clear_pulse();
    n_total++; if (bus.parity_error !== 1'b0) $display("FAIL par_clear: got %b expected 0", bus.parity_error); else n_pass++;
    send(8'h07, 1, 1, -1);
    model_frame(8'h07, 1, 1);
    read_strobe(d, v);
    e = q.pop_front();
    n_total++; if (v !== 1'b1 || d !== e) $display("FAIL par_good_byte: got %b/%h expected 1/%h", v, d, e); else n_pass++;
  endtask
`endif
  task automatic test_reset_flush;
    send(8'h9E, 1, 1, -1);
    model_frame(8'h9E, 1, 1);
    n_total++; if (bus.count !== 5'(q.size())) $display("FAIL flush_pre_count: got %0d expected %0d", bus.count, q.size()); else n_pass++;
    test_reset();
  endtask
  initial begin
    test_reset();
    test_single();
    test_random();
    test_overrun_full_pop();
    test_frame_error();
    test_glitch();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
  initial begin
    #6ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
